// File: rtl/acq_sequencer.sv
// Sequences N triggered ADC captures: pre-fill, arm, post-capture, AXIS drain.
// Latency: every output is registered and changes one cycle after the event that causes it.
// Backpressure: waits on streamer status levels/pulses; optional auto-trigger timeout (ACQ_SEQ_AUTO_TRIG_EN).
module acq_sequencer #(
  parameter int CNT_W   = 16,
  parameter int DEPTH_W = 29,
  parameter int TMO_W   = 24
) (
  input  logic               acq_clk,
  input  logic               acq_rst,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic [CNT_W-1:0]   cfg_num_acq,
  input  logic [DEPTH_W-1:0] cfg_pre_words,
  input  logic [TMO_W-1:0]   cfg_tmo_cycles,
  input  logic               adc_data_valid,
  input  logic               acq_done,
  input  logic               acq_have_trig,
  input  logic               axis_last_beat,
  output logic               acq_run,
  output logic               acq_abort,
  output logic               acq_trig_mask,
  output logic               acq_trig_rst,
  output logic               acq_depth_mux,
  output logic               acq_axi_run,
  output logic [2:0]         seq_state,
  output logic [CNT_W-1:0]   seq_acq_count,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               seq_forced_trig
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_PRE   = 3'd2,
    S_ARMED = 3'd3,
    S_POST  = 3'd4,
    S_DRAIN = 3'd5,
    S_NEXT  = 3'd6,
    S_ABORT = 3'd7
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   num_acq_q;
  logic [DEPTH_W-1:0] pre_words_q;
  logic [DEPTH_W-1:0] pre_ctr;
  logic               tmo_hit;

  logic run_d, abort_d, mask_d, trst_d, mux_d, axi_d, done_d;

`ifdef ACQ_SEQ_AUTO_TRIG_EN
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_ctr;
  // Timeout fires on the cycle the counter would reach zero, so POST starts tmo cycles after ARMED.
  assign tmo_hit = (tmo_q != '0) && (tmo_ctr == TMO_W'(1));
`else
  logic unused_tmo;
  assign unused_tmo = ^cfg_tmo_cycles;
  assign tmo_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge acq_clk) begin
    if (acq_rst) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state selection; stop overrides every other transition once a sequence is running.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (cmd_start) next_state = S_CLR;
      S_CLR:   next_state = (pre_words_q == '0) ? S_ARMED : S_PRE;
      S_PRE:   if (adc_data_valid && (pre_ctr == pre_words_q - DEPTH_W'(1))) next_state = S_ARMED;
      S_ARMED: if (acq_have_trig || tmo_hit) next_state = S_POST;
      S_POST:  if (acq_done) next_state = S_DRAIN;
      S_DRAIN: if (axis_last_beat) next_state = S_NEXT;
      S_NEXT:  next_state = ((num_acq_q != '0) && (seq_acq_count + CNT_W'(1) == num_acq_q))
                            ? S_IDLE : S_CLR;
      S_ABORT: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (cmd_stop && (state != S_IDLE) && (state != S_ABORT)) next_state = S_ABORT;
  end

  // Output decode from the upcoming state so the registered pins line up with seq_state.
  always_comb begin
    run_d   = 1'b0;
    abort_d = 1'b0;
    mask_d  = 1'b1;
    trst_d  = 1'b0;
    mux_d   = 1'b0;
    axi_d   = 1'b0;
    case (next_state)
      S_CLR:   trst_d  = 1'b1;
      S_PRE:   run_d   = 1'b1;
      S_ARMED: begin run_d = 1'b1; mask_d = 1'b0; end
      S_POST:  begin run_d = 1'b1; mux_d  = 1'b1; end
      S_DRAIN: axi_d   = 1'b1;
      S_ABORT: abort_d = 1'b1;
      default: ;
    endcase
    done_d = (state == S_ABORT) || ((state == S_NEXT) && (next_state == S_IDLE));
  end

  // Output register.
  always_ff @(posedge acq_clk) begin
    if (acq_rst) begin
      acq_run       <= 1'b0;
      acq_abort     <= 1'b0;
      acq_trig_mask <= 1'b1;
      acq_trig_rst  <= 1'b0;
      acq_depth_mux <= 1'b0;
      acq_axi_run   <= 1'b0;
      seq_busy      <= 1'b0;
      seq_done      <= 1'b0;
    end else begin
      acq_run       <= run_d;
      acq_abort     <= abort_d;
      acq_trig_mask <= mask_d;
      acq_trig_rst  <= trst_d;
      acq_depth_mux <= mux_d;
      acq_axi_run   <= axi_d;
      seq_busy      <= (next_state != S_IDLE);
      seq_done      <= done_d;
    end
  end

  // Config latch, capture counter, pre-fill counter and forced-trigger flag.
  always_ff @(posedge acq_clk) begin
    if (acq_rst) begin
      num_acq_q       <= '0;
      pre_words_q     <= '0;
      pre_ctr         <= '0;
      seq_acq_count   <= '0;
      seq_forced_trig <= 1'b0;
`ifdef ACQ_SEQ_AUTO_TRIG_EN
      tmo_q           <= '0;
      tmo_ctr         <= '0;
`endif
    end else begin
      if ((state == S_IDLE) && cmd_start) begin
        num_acq_q       <= cfg_num_acq;
        pre_words_q     <= cfg_pre_words;
        seq_acq_count   <= '0;
        seq_forced_trig <= 1'b0;
`ifdef ACQ_SEQ_AUTO_TRIG_EN
        tmo_q           <= cfg_tmo_cycles;
`endif
      end
      if (state == S_NEXT) seq_acq_count <= seq_acq_count + CNT_W'(1);
      if (state == S_CLR) pre_ctr <= '0;
      else if ((state == S_PRE) && adc_data_valid) pre_ctr <= pre_ctr + DEPTH_W'(1);
`ifdef ACQ_SEQ_AUTO_TRIG_EN
      if ((state != S_ARMED) && (next_state == S_ARMED)) tmo_ctr <= tmo_q;
      else if ((state == S_ARMED) && (tmo_ctr != '0)) tmo_ctr <= tmo_ctr - TMO_W'(1);
      if ((state == S_ARMED) && (next_state == S_POST) && !acq_have_trig) seq_forced_trig <= 1'b1;
`endif
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: random capture sequences against a phase-level model.
// Inputs driven 1 time unit after posedge, outputs sampled there too.
// Streamer handshakes are issued at random gaps; model tracks captures completed.
module tb_acq_sequencer;
  localparam int CNT_W = 16, DEPTH_W = 29, TMO_W = 24;

  logic               acq_clk = 1'b0;
  logic               acq_rst = 1'b1;
  logic               cmd_start = 1'b0, cmd_stop = 1'b0;
  logic [CNT_W-1:0]   cfg_num_acq = '0;
  logic [DEPTH_W-1:0] cfg_pre_words = '0;
  logic [TMO_W-1:0]   cfg_tmo_cycles = '0;
  logic               adc_data_valid = 1'b0, acq_done = 1'b0, acq_have_trig = 1'b0, axis_last_beat = 1'b0;
  logic               acq_run, acq_abort, acq_trig_mask, acq_trig_rst, acq_depth_mux, acq_axi_run;
  logic [2:0]         seq_state;
  logic [CNT_W-1:0]   seq_acq_count;
  logic               seq_busy, seq_done, seq_forced_trig;

  acq_sequencer #(.CNT_W(CNT_W), .DEPTH_W(DEPTH_W), .TMO_W(TMO_W)) dut (
    .acq_clk(acq_clk), .acq_rst(acq_rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cfg_num_acq(cfg_num_acq), .cfg_pre_words(cfg_pre_words), .cfg_tmo_cycles(cfg_tmo_cycles),
    .adc_data_valid(adc_data_valid), .acq_done(acq_done), .acq_have_trig(acq_have_trig),
    .axis_last_beat(axis_last_beat), .acq_run(acq_run), .acq_abort(acq_abort),
    .acq_trig_mask(acq_trig_mask), .acq_trig_rst(acq_trig_rst), .acq_depth_mux(acq_depth_mux),
    .acq_axi_run(acq_axi_run), .seq_state(seq_state), .seq_acq_count(seq_acq_count),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_forced_trig(seq_forced_trig)
  );

  always #5 acq_clk = ~acq_clk;

  // Phase numbers as seen on seq_state.
  localparam int P_IDLE = 0, P_CLR = 1, P_PRE = 2, P_ARMED = 3, P_POST = 4, P_DRAIN = 5, P_NEXT = 6, P_ABORT = 7;

  int n_checks = 0;
  int n_fail   = 0;
  // Model: captures requested and completed in the current sequence.
  int m_num    = 0;
  int m_count  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge acq_clk);
    #1;
  endtask

  task automatic idle_gap(input int max_gap, input string tag, input int phase);
    int g;
    g = int'($urandom_range(0, max_gap));
    for (int i = 0; i < g; i++) begin
      tick();
      chk(tag, int'(seq_state), phase);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, int'(seq_state), P_IDLE);
    chk({tag, "_run"},   int'(acq_run), 0);
    chk({tag, "_abort"}, int'(acq_abort), 0);
    chk({tag, "_mask"},  int'(acq_trig_mask), 1);
    chk({tag, "_trst"},  int'(acq_trig_rst), 0);
    chk({tag, "_mux"},   int'(acq_depth_mux), 0);
    chk({tag, "_axi"},   int'(acq_axi_run), 0);
    chk({tag, "_count"}, int'(seq_acq_count), 0);
    chk({tag, "_busy"},  int'(seq_busy), 0);
    chk({tag, "_done"},  int'(seq_done), 0);
    chk({tag, "_forced"}, int'(seq_forced_trig), 0);
  endtask

  // Start a sequence; optionally collide with stop (start must win), then scramble config.
  task automatic start_seq(input int num, input int pre);
    cfg_num_acq   = CNT_W'(num);
    cfg_pre_words = DEPTH_W'(pre);
    cmd_start = 1'b1;
    cmd_stop  = 1'($urandom_range(0, 1));
    tick();
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    m_num   = num;
    m_count = 0;
    chk("start_state", int'(seq_state), P_CLR);
    chk("start_count", int'(seq_acq_count), 0);
    chk("start_forced", int'(seq_forced_trig), 0);
    chk("start_busy", int'(seq_busy), 1);
    cfg_num_acq   = CNT_W'($urandom_range(1, 9));
    cfg_pre_words = DEPTH_W'($urandom_range(0, 9));
  endtask

  task automatic do_stop();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    chk("abort_state", int'(seq_state), P_ABORT);
    chk("abort_pulse", int'(acq_abort), 1);
    chk("abort_run", int'(acq_run), 0);
    chk("abort_axi", int'(acq_axi_run), 0);
    chk("abort_mask", int'(acq_trig_mask), 1);
    tick();
    chk("abort_idle", int'(seq_state), P_IDLE);
    chk("abort_done", int'(seq_done), 1);
    chk("abort_pulse_end", int'(acq_abort), 0);
    chk("abort_busy", int'(seq_busy), 0);
    chk("abort_count", int'(seq_acq_count), m_count % 65536);
    tick();
    chk("done_pulse_end", int'(seq_done), 0);
  endtask

  // One capture, entered with the DUT in CLR. stop_at selects a phase to abort/hold in.
  task automatic run_capture(input int pre, input int stop_at);
    chk("clr_state", int'(seq_state), P_CLR);
    chk("clr_trig_rst", int'(acq_trig_rst), 1);
    chk("clr_mask", int'(acq_trig_mask), 1);
    chk("clr_mux", int'(acq_depth_mux), 0);
    tick();
    chk("after_clr_state", int'(seq_state), (pre == 0) ? P_ARMED : P_PRE);
    chk("trig_rst_width", int'(acq_trig_rst), 0);
    for (int n = 0; n < pre; n++) begin
      idle_gap(2, "pre_hold", P_PRE);
      chk("pre_run", int'(acq_run), 1);
      adc_data_valid = 1'b1;
      tick();
      adc_data_valid = 1'b0;
      chk("pre_fill", int'(seq_state), (n == pre - 1) ? P_ARMED : P_PRE);
    end
    chk("armed_mask", int'(acq_trig_mask), 0);
    chk("armed_run", int'(acq_run), 1);
    if (stop_at == P_ARMED) return;
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      cmd_start = 1'($urandom_range(0, 1));
      tick();
      cmd_start = 1'b0;
      chk("armed_hold", int'(seq_state), P_ARMED);
    end
    acq_have_trig = 1'b1;
    tick();
    acq_have_trig = 1'b0;
    chk("post_state", int'(seq_state), P_POST);
    chk("post_mask", int'(acq_trig_mask), 1);
    chk("post_mux", int'(acq_depth_mux), 1);
    chk("post_run", int'(acq_run), 1);
    if (stop_at == P_POST) begin do_stop(); return; end
    idle_gap(3, "post_hold", P_POST);
    acq_done = 1'b1;
    tick();
    acq_done = 1'b0;
    chk("drain_state", int'(seq_state), P_DRAIN);
    chk("drain_axi", int'(acq_axi_run), 1);
    chk("drain_run", int'(acq_run), 0);
    if (stop_at == P_DRAIN) begin do_stop(); return; end
    idle_gap(3, "drain_hold", P_DRAIN);
    axis_last_beat = 1'b1;
    tick();
    axis_last_beat = 1'b0;
    chk("next_state", int'(seq_state), P_NEXT);
    m_count++;
    tick();
    if (m_num != 0 && m_count == m_num) begin
      chk("seq_end_state", int'(seq_state), P_IDLE);
      chk("seq_end_done", int'(seq_done), 1);
      chk("seq_end_busy", int'(seq_busy), 0);
    end else begin
      chk("next_to_clr", int'(seq_state), P_CLR);
      chk("next_no_done", int'(seq_done), 0);
    end
    chk("capture_count", int'(seq_acq_count), m_count % 65536);
  endtask

  initial begin
    int num, pre, k;
    tick();
    tick();
    acq_rst = 1'b0;
    check_reset_values("rst");

    // Stop while idle does nothing.
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    chk("idle_stop_state", int'(seq_state), P_IDLE);
    chk("idle_stop_abort", int'(acq_abort), 0);

    // Two captures of four pre-words each.
    start_seq(2, 4);
    run_capture(4, -1);
    run_capture(4, -1);

    // Random sequences, including zero pre-fill.
    for (int s = 0; s < 6; s++) begin
      num = int'($urandom_range(1, 3));
      pre = int'($urandom_range(0, 6));
      start_seq(num, pre);
      for (int c = 0; c < num; c++) run_capture(pre, -1);
    end

    // Stop during POST.
    start_seq(1, 2);
    run_capture(2, P_POST);

    // Continuous mode: five captures, then stop in DRAIN.
    start_seq(0, 1);
    for (int c = 0; c < 5; c++) run_capture(1, -1);
    run_capture(1, P_DRAIN);

    // Reset while ARMED returns to reset values with no abort pulse.
    start_seq(1, 3);
    run_capture(3, P_ARMED);
    acq_rst = 1'b1;
    tick();
    acq_rst = 1'b0;
    check_reset_values("midrst");

    // Auto-trigger timeout.
    cfg_tmo_cycles = TMO_W'(10);
    start_seq(1, 0);
    cfg_tmo_cycles = TMO_W'($urandom_range(1, 50));
    tick();
    chk("tmo_armed", int'(seq_state), P_ARMED);
`ifdef ACQ_SEQ_AUTO_TRIG_EN
    k = 0;
    while (int'(seq_state) == P_ARMED && k < 50) begin
      tick();
      k++;
    end
    chk("tmo_latency", k, 10);
    chk("tmo_post", int'(seq_state), P_POST);
    chk("tmo_mask", int'(acq_trig_mask), 1);
    chk("tmo_forced", int'(seq_forced_trig), 1);
`else
    k = 0;
    repeat (30) tick();
    chk("tmo_stays_armed", int'(seq_state), P_ARMED);
    chk("tmo_forced_off", int'(seq_forced_trig), 0);
    acq_have_trig = 1'b1;
    tick();
    acq_have_trig = 1'b0;
    chk("tmo_trig_post", int'(seq_state), P_POST);
`endif
    acq_done = 1'b1;
    tick();
    acq_done = 1'b0;
    axis_last_beat = 1'b1;
    tick();
    axis_last_beat = 1'b0;
    tick();
    chk("tmo_seq_idle", int'(seq_state), P_IDLE);
    chk("tmo_seq_done", int'(seq_done), 1);
    chk("tmo_count", int'(seq_acq_count), 1);

    // A new start clears the forced flag.
    cfg_tmo_cycles = '0;
    start_seq(1, 1);
    run_capture(1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
